// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default parameter values for the pipeline stall controller.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FREEZE = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } ctrl_state_e;

   localparam int unsigned DEF_CNT_W        = 16;
   localparam int unsigned DEF_DRAIN_CYCLES = 4;
   localparam int unsigned DEF_MAX_MEM_WAIT = 15;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   // Count up on inc, hold at saturation, clear on rst or clr.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline write-enable / flush controller: load-use stalls, branch flushes,
// memory freezes with timeout detection, halt drain, and event counters.
module pipeline_stall_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W        = DEF_CNT_W,
   parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int unsigned MAX_MEM_WAIT = DEF_MAX_MEM_WAIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_req,
   input  logic             branch_taken,
   input  logic             mem_busy,
   input  logic             halt_ID,
   input  logic             cnt_clr,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             back_hold,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] freeze_cnt
);

   localparam int unsigned WAIT_W  = $clog2(MAX_MEM_WAIT + 1);
   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MAX_MEM_WAIT);
   localparam logic [WAIT_W-1:0]  WAIT_TRIG  = WAIT_W'(MAX_MEM_WAIT - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

   ctrl_state_e        state, state_nxt;
   logic               pending, pending_nxt;
   logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
   logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
   logic               timeout_set;
   logic               run_eval;
   logic               branch_eff;
   logic               inc_stall, inc_flush, inc_freeze;

   // State, pending branch and sticky timeout registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         pending     <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         if (timeout_set) begin
            mem_timeout <= 1'b1;
         end
      end
   end

   // Memory-wait and drain countdown registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         wait_cnt  <= wait_nxt;
         drain_cnt <= drain_nxt;
      end
   end

   // Next-state and zero-latency control outputs from state and requests.
   // A FREEZE release cycle reuses the RUN priority chain with the pending
   // branch folded in, so both paths share one set of RUN rules below.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      back_hold   = 1'b0;
      halted      = (state == HALTED);
      state_nxt   = state;
      pending_nxt = pending;
      wait_nxt    = wait_cnt;
      drain_nxt   = drain_cnt;
      timeout_set = 1'b0;
      run_eval    = 1'b0;
      branch_eff  = branch_taken;
      inc_stall   = 1'b0;
      inc_flush   = 1'b0;
      inc_freeze  = 1'b0;

      case (state)
         RUN: begin
            run_eval = 1'b1;
         end
         FREEZE: begin
            if (mem_busy) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               back_hold  = 1'b1;
               inc_freeze = 1'b1;
               if (wait_cnt != WAIT_MAX) begin
                  wait_nxt = wait_cnt + 1'b1;
               end
               if (wait_cnt >= WAIT_TRIG) begin
                  timeout_set = 1'b1;
               end
            end else begin
               run_eval    = 1'b1;
               branch_eff  = branch_taken | pending;
               pending_nxt = 1'b0;
            end
         end
         DRAIN: begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            if (mem_busy) begin
               back_hold = 1'b1;
            end else if (branch_taken) begin
               pc_write   = 1'b1;
               idex_flush = 1'b1;
               inc_flush  = 1'b1;
               state_nxt  = RUN;
            end else if (drain_cnt <= DRAIN_LAST) begin
               drain_nxt = '0;
               state_nxt = HALTED;
            end else begin
               drain_nxt = drain_cnt - 1'b1;
            end
         end
         HALTED: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase

      if (run_eval) begin
         state_nxt = RUN;
         if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            back_hold   = 1'b1;
            state_nxt   = FREEZE;
            wait_nxt    = '0;
            pending_nxt = branch_taken;
         end else if (branch_eff) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            inc_flush  = 1'b1;
         end else if (stall_req) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            inc_stall  = 1'b1;
         end else if (halt_ID) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            state_nxt  = DRAIN;
            drain_nxt  = DRAIN_LOAD;
         end
      end

      if (rst) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         back_hold  = 1'b0;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (inc_stall),
      .q   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (inc_flush),
      .q   (flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_freeze_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (inc_freeze),
      .q   (freeze_cnt)
   );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: constant vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_pipeline_stall_ctrl;

   localparam int unsigned CNT_W        = 4;
   localparam int unsigned DRAIN_CYCLES = 4;
   localparam int unsigned MAX_MEM_WAIT = 15;
   localparam int unsigned CNT_MAX      = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             stall_req = 1'b0;
   logic             branch_taken = 1'b0;
   logic             mem_busy = 1'b0;
   logic             halt_ID = 1'b0;
   logic             cnt_clr = 1'b0;
   logic             pc_write, ifid_write, ifid_flush, idex_flush, back_hold;
   logic             halted, mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
   logic [4:0]       ctrl_now;
   logic [4:0]       ctrl_s;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(
      .CNT_W        (CNT_W),
      .DRAIN_CYCLES (DRAIN_CYCLES),
      .MAX_MEM_WAIT (MAX_MEM_WAIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_req    (stall_req),
      .branch_taken (branch_taken),
      .mem_busy     (mem_busy),
      .halt_ID      (halt_ID),
      .cnt_clr      (cnt_clr),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .back_hold    (back_hold),
      .halted       (halted),
      .mem_timeout  (mem_timeout),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .freeze_cnt   (freeze_cnt)
   );

   // Control vector order: {pc_write, ifid_write, ifid_flush, idex_flush, back_hold}
   assign ctrl_now = {pc_write, ifid_write, ifid_flush, idex_flush, back_hold};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Pipeline condition as flags: frozen on memory, draining toward halt
   // (m_prog = drain cycles completed, counting the accepting cycle), halted.
   bit          m_frozen, m_pend, m_drain, m_halted, m_tmo;
   int unsigned m_prog, m_wait, m_sc, m_fc, m_zc;
   logic [4:0]  m_ctrl;

   function automatic int unsigned sat_inc(input int unsigned v, input bit inc);
      return (inc && v < CNT_MAX) ? v + 1 : v;
   endfunction

   task automatic model_step(input bit r, m, b, s, h, c);
      bit br_eff;
      bit inc_s, inc_f, inc_z;
      inc_s = 0; inc_f = 0; inc_z = 0;
      if (r) begin
         m_ctrl = 5'b00110;
         m_frozen = 0; m_pend = 0; m_drain = 0; m_halted = 0; m_tmo = 0;
         m_prog = 0; m_wait = 0; m_sc = 0; m_fc = 0; m_zc = 0;
         return;
      end
      if (m_halted) begin
         m_ctrl = 5'b00110;
      end else if (m_drain) begin
         if (m) m_ctrl = 5'b01101;
         else if (b) begin
            m_ctrl = 5'b11110; inc_f = 1; m_drain = 0;
         end else begin
            m_ctrl = 5'b01100;
            m_prog++;
            if (m_prog == DRAIN_CYCLES) begin m_drain = 0; m_halted = 1; end
         end
      end else if (m_frozen && m) begin
         m_ctrl = 5'b00001;
         inc_z = 1;
         if (m_wait < MAX_MEM_WAIT) m_wait++;
         if (m_wait == MAX_MEM_WAIT) m_tmo = 1;
      end else begin
         br_eff = b | (m_frozen & m_pend);
         m_frozen = 0; m_pend = 0;
         if (m) begin
            m_ctrl = 5'b00001; m_frozen = 1; m_pend = b; m_wait = 0;
         end else if (br_eff) begin
            m_ctrl = 5'b11110; inc_f = 1;
         end else if (s) begin
            m_ctrl = 5'b00010; inc_s = 1;
         end else if (h) begin
            m_ctrl = 5'b01100; m_drain = 1; m_prog = 1;
         end else begin
            m_ctrl = 5'b11000;
         end
      end
      if (c) begin
         m_sc = 0; m_fc = 0; m_zc = 0;
      end else begin
         m_sc = sat_inc(m_sc, inc_s);
         m_fc = sat_inc(m_fc, inc_f);
         m_zc = sat_inc(m_zc, inc_z);
      end
   endtask

   // One clock: drive, sample control mid-cycle, then sample status after the edge.
   task automatic cycle(input bit r, m, b, s, h, c);
      rst = r; mem_busy = m; branch_taken = b; stall_req = s; halt_ID = h; cnt_clr = c;
      model_step(r, m, b, s, h, c);
      #3;
      ctrl_s = ctrl_now;
      check("model_ctrl", 32'(ctrl_s), 32'(m_ctrl));
      @(posedge clk);
      #1;
      check("model_halted", 32'(halted), 32'(m_halted));
      check("model_timeout", 32'(mem_timeout), 32'(m_tmo));
      check("model_stall_cnt", 32'(stall_cnt), m_sc);
      check("model_flush_cnt", 32'(flush_cnt), m_fc);
      check("model_freeze_cnt", 32'(freeze_cnt), m_zc);
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0, 0, 0);
   endtask

   // ---------------- constant vector table ----------------
   typedef struct {
      bit          r, m, b, s, h, c;
      logic [4:0]  ctrl;
      int unsigned sc, fc, zc;
      bit          hl, tm;
   } vec_t;

   vec_t tbl[20];

   initial begin
      int unsigned lat;
      bit          seen;
      bit          mprev;

      //           r  m  b  s  h  c  ctrl      sc fc zc hl tm
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 5'b00110, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0, 5'b11000, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 0, 1, 0, 0, 5'b00010, 1, 0, 0, 0, 0};
      tbl[3]  = '{0, 0, 0, 0, 0, 0, 5'b11000, 1, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 1, 1, 0, 0, 5'b11110, 1, 1, 0, 0, 0};
      tbl[5]  = '{0, 1, 1, 0, 0, 0, 5'b00001, 1, 1, 0, 0, 0};
      tbl[6]  = '{0, 1, 0, 0, 0, 0, 5'b00001, 1, 1, 1, 0, 0};
      tbl[7]  = '{0, 1, 0, 0, 0, 0, 5'b00001, 1, 1, 2, 0, 0};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 5'b11110, 1, 2, 2, 0, 0};
      tbl[9]  = '{0, 1, 0, 1, 0, 0, 5'b00001, 1, 2, 2, 0, 0};
      tbl[10] = '{0, 0, 0, 1, 0, 0, 5'b00010, 2, 2, 2, 0, 0};
      tbl[11] = '{0, 0, 0, 1, 0, 1, 5'b00010, 0, 0, 0, 0, 0};
      tbl[12] = '{0, 0, 0, 0, 1, 0, 5'b01100, 0, 0, 0, 0, 0};
      tbl[13] = '{0, 0, 0, 1, 1, 0, 5'b01100, 0, 0, 0, 0, 0};
      tbl[14] = '{0, 1, 0, 0, 0, 0, 5'b01101, 0, 0, 0, 0, 0};
      tbl[15] = '{0, 0, 0, 0, 0, 0, 5'b01100, 0, 0, 0, 0, 0};
      tbl[16] = '{0, 0, 0, 0, 0, 0, 5'b01100, 0, 0, 0, 1, 0};
      tbl[17] = '{0, 1, 1, 1, 0, 0, 5'b00110, 0, 0, 0, 1, 0};
      tbl[18] = '{1, 0, 0, 0, 0, 0, 5'b00110, 0, 0, 0, 0, 0};
      tbl[19] = '{0, 0, 0, 0, 0, 0, 5'b11000, 0, 0, 0, 0, 0};

      for (int i = 0; i < 20; i++) begin
         cycle(tbl[i].r, tbl[i].m, tbl[i].b, tbl[i].s, tbl[i].h, tbl[i].c);
         check($sformatf("tbl%0d_ctrl", i), 32'(ctrl_s), 32'(tbl[i].ctrl));
         check($sformatf("tbl%0d_stall_cnt", i), 32'(stall_cnt), tbl[i].sc);
         check($sformatf("tbl%0d_flush_cnt", i), 32'(flush_cnt), tbl[i].fc);
         check($sformatf("tbl%0d_freeze_cnt", i), 32'(freeze_cnt), tbl[i].zc);
         check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].hl));
         check($sformatf("tbl%0d_timeout", i), 32'(mem_timeout), 32'(tbl[i].tm));
      end

      // Halt latency without and with a two-cycle memory stall during drain.
      do_reset();
      cycle(0, 0, 0, 0, 1, 0);
      lat = 1;
      while (!halted && lat < 20) begin cycle(0, 0, 0, 0, 0, 0); lat++; end
      check("halt_latency", lat, DRAIN_CYCLES);

      do_reset();
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      lat = 3;
      while (!halted && lat < 20) begin cycle(0, 0, 0, 0, 0, 0); lat++; end
      check("halt_latency_mem", lat, DRAIN_CYCLES + 2);

      // Wrong-path halt cancelled by a branch at drain cycle 2.
      do_reset();
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      check("drain_branch_ctrl", 32'(ctrl_s), 32'(5'b11110));
      check("drain_branch_flush_cnt", 32'(flush_cnt), 1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         if (halted) seen = 1;
      end
      check("halt_cancelled", 32'(seen), 0);
      check("after_cancel_ctrl", 32'(ctrl_s), 32'(5'b11000));

      // Reset in the middle of a drain.
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      check("rst_drain_stall_cnt", 32'(stall_cnt), 0);
      check("rst_drain_flush_cnt", 32'(flush_cnt), 0);
      cycle(0, 0, 0, 0, 0, 0);
      check("rst_drain_ctrl", 32'(ctrl_s), 32'(5'b11000));
      check("rst_drain_halted", 32'(halted), 0);

      // Memory timeout boundary and stickiness.
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         cycle(0, 1, 0, 0, 0, 0);
         if (i == 15) check("timeout_at_15", 32'(mem_timeout), 0);
      end
      check("timeout_at_16", 32'(mem_timeout), 1);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);
      check("timeout_sticky", 32'(mem_timeout), 1);
      do_reset();
      check("timeout_cleared_by_rst", 32'(mem_timeout), 0);

      // Counter saturation and clear-over-increment.
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0, 0);
      check("stall_cnt_saturated", 32'(stall_cnt), CNT_MAX);
      cycle(0, 0, 0, 1, 0, 1);
      check("stall_cnt_clr_wins", 32'(stall_cnt), 0);

      // Randomized traffic against the model.
      do_reset();
      mprev = 0;
      for (int i = 0; i < 3000; i++) begin
         bit r, m, b, s, h, c;
         r = ($urandom_range(0, 99) < 2);
         m = mprev ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 15);
         b = ($urandom_range(0, 99) < 20);
         s = ($urandom_range(0, 99) < 25);
         h = ($urandom_range(0, 99) < 5);
         c = ($urandom_range(0, 99) < 3);
         mprev = m;
         cycle(r, m, b, s, h, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
